// File: rtl/wb_port_sched_pkg.sv
// Shared CPU definitions for the writeback port scheduler: register-write packs,
// issue width and the long-latency pending entry. Types only, no timing or handshake.
package wb_port_sched_pkg;

    localparam int ISSUE_NUM = 2;
    localparam int LL_DEPTH  = 2;
    localparam int PORT_W    = (ISSUE_NUM > 1) ? $clog2(ISSUE_NUM) : 1;

    typedef struct packed {
        logic        rd_en;
        logic [4:0]  rd;
        logic [63:0] res;
    } regpack_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [63:0] res;
    } ll_entry_t;

endpackage

// File: rtl/wb_ll_fifo.sv
// Two-entry pending buffer for long-latency results; head visible combinationally, push lands next cycle.
// No internal overflow guard: the owner must hold push low while count is full.
module wb_ll_fifo
    import wb_port_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  ll_entry_t  push_dat,
    input  logic       pop,
    output ll_entry_t  head_dat,
    output logic [1:0] count
);

    ll_entry_t  mem_q [LL_DEPTH];
    logic       head_q, head_d;
    logic       tail_q, tail_d;
    logic [1:0] count_q, count_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) tail_d = ~tail_q;
        if (pop)  head_d = ~head_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            count_q <= 2'd0;
            for (int i = 0; i < LL_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (push) mem_q[tail_q] <= push_dat;
        end
    end

    assign head_dat = mem_q[head_q];
    assign count    = count_q;

endmodule

// File: rtl/wb_port_sched.sv
// Merges in-order lane writes with long-latency results onto the regfile write ports; bypass in 0 cycles.
// Long-latency source is throttled by ll_ready, which drops only when both pending entries are occupied.
module wb_port_sched
    import wb_port_sched_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall_wb,
    input  regpack_t [ISSUE_NUM-1:0]  lane_get,
    input  logic                      ll_valid,
    output logic                      ll_ready,
    input  logic [4:0]                ll_rd,
    input  logic [63:0]               ll_res,
    output regpack_t [ISSUE_NUM-1:0]  wb_put,
    output logic [1:0]                ll_count
);

    logic [ISSUE_NUM-1:0] lane_en;
    logic                 fifo_push, fifo_pop;
    ll_entry_t            fifo_head;
    logic [1:0]           fifo_cnt;
    logic                 from_fifo, accept, cand_vld, cand_zero;
    ll_entry_t            cand;
    logic                 collide, port_free, ll_wr, retire;
    logic [PORT_W-1:0]    port_sel;

    always_comb begin
        for (int i = 0; i < ISSUE_NUM; i++) begin
            lane_en[i] = lane_get[i].rd_en && !stall_wb && (lane_get[i].rd != 5'd0);
        end
    end

    assign ll_ready  = (fifo_cnt != 2'd2);
    assign ll_count  = fifo_cnt;
    assign accept    = ll_valid && ll_ready;
    assign from_fifo = (fifo_cnt != 2'd0);
    assign cand      = from_fifo ? fifo_head : '{rd: ll_rd, res: ll_res};
    // Nothing long-latency may reach a port while reset is held.
    assign cand_vld  = !rst && (from_fifo || ll_valid);
    assign cand_zero = (cand.rd == 5'd0);

    always_comb begin
        collide   = 1'b0;
        port_free = 1'b0;
        port_sel  = '0;
        for (int i = 0; i < ISSUE_NUM; i++) begin
            if (lane_en[i] && (lane_get[i].rd == cand.rd)) collide = 1'b1;
        end
        for (int i = ISSUE_NUM - 1; i >= 0; i--) begin
            if (!lane_en[i]) begin
                port_free = 1'b1;
                port_sel  = PORT_W'(i);
            end
        end
    end

    assign ll_wr  = cand_vld && !cand_zero && port_free && !collide;
    assign retire = cand_vld && (cand_zero || ll_wr);

    // With a non-empty buffer the incoming result always queues behind the head.
    assign fifo_push = accept && (from_fifo || !retire);
    assign fifo_pop  = from_fifo && retire;

    always_comb begin
        for (int i = 0; i < ISSUE_NUM; i++) begin
            wb_put[i] = '0;
            if (lane_en[i]) begin
                wb_put[i] = lane_get[i];
            end else if (ll_wr && (port_sel == PORT_W'(i))) begin
                wb_put[i] = '{rd_en: 1'b1, rd: cand.rd, res: cand.res};
            end
        end
    end

    wb_ll_fifo u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .push_dat ('{rd: ll_rd, res: ll_res}),
        .pop      (fifo_pop),
        .head_dat (fifo_head),
        .count    (fifo_cnt)
    );

endmodule

// File: tb/tb_wb_port_sched.sv
// Scenario bench for wb_port_sched: long-latency results are queued as expected writes and
// popped by a port monitor; each scenario task also checks ports, ll_count and ll_ready inline.
module tb_wb_port_sched;
    import wb_port_sched_pkg::*;

    localparam logic [63:0] LANE_TAG = 64'hA0A0_0000_0000_0000;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     stall_wb;
    regpack_t [ISSUE_NUM-1:0] lane_get;
    logic                     ll_valid;
    logic                     ll_ready;
    logic [4:0]               ll_rd;
    logic [63:0]              ll_res;
    regpack_t [ISSUE_NUM-1:0] wb_put;
    logic [1:0]               ll_count;

    int        n_cmp = 0;
    int        n_bad = 0;
    ll_entry_t sb [$];

    logic [ISSUE_NUM-1:0] mon_lane;
    int                   mon_n;
    ll_entry_t            mon_exp;

    always #5 clk = ~clk;

    wb_port_sched dut (
        .clk      (clk),
        .rst      (rst),
        .stall_wb (stall_wb),
        .lane_get (lane_get),
        .ll_valid (ll_valid),
        .ll_ready (ll_ready),
        .ll_rd    (ll_rd),
        .ll_res   (ll_res),
        .wb_put   (wb_put),
        .ll_count (ll_count)
    );

    function automatic regpack_t mk(input logic [4:0] rd, input logic [63:0] res);
        regpack_t p;
        p.rd_en = 1'b1;
        p.rd    = rd;
        p.res   = res;
        return p;
    endfunction

    function automatic ll_entry_t ent(input logic [4:0] rd, input logic [63:0] res);
        ll_entry_t e;
        e.rd  = rd;
        e.res = res;
        return e;
    endfunction

    // One clock: drive just after the rising edge, return at the falling edge for sampling.
    task automatic cyc(input logic r, input logic l0v, input logic [4:0] l0rd,
                       input logic l1v, input logic [4:0] l1rd, input logic st,
                       input logic lv, input logic [4:0] lrd, input logic [63:0] lres);
        @(posedge clk);
        #1;
        rst         = r;
        stall_wb    = st;
        lane_get[0] = l0v ? mk(l0rd, LANE_TAG | 64'(l0rd)) : '0;
        lane_get[1] = l1v ? mk(l1rd, LANE_TAG | 64'(l1rd)) : '0;
        ll_valid    = lv;
        ll_rd       = lrd;
        ll_res      = lres;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 64'd0);
    endtask

    // Port monitor: lane writes must pass through, any other enabled write must be the next queued result.
    always @(negedge clk) begin
        mon_n = 0;
        for (int p = 0; p < ISSUE_NUM; p++) begin
            mon_lane[p] = lane_get[p].rd_en && !stall_wb && (lane_get[p].rd != 5'd0);
        end
        for (int p = 0; p < ISSUE_NUM; p++) begin
            n_cmp++;
            if (mon_lane[p]) begin
                if (wb_put[p] !== lane_get[p]) begin
                    n_bad++;
                    $display("FAIL lane_port%0d: got %h want %h", p, wb_put[p], lane_get[p]);
                end
            end else if (wb_put[p].rd_en === 1'b1) begin
                mon_n++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_ll_write port%0d: got rd=%0d res=%h want no write",
                             p, wb_put[p].rd, wb_put[p].res);
                end else begin
                    mon_exp = sb.pop_front();
                    if ({wb_put[p].rd, wb_put[p].res} !== mon_exp) begin
                        n_bad++;
                        $display("FAIL ll_order port%0d: got rd=%0d res=%h want rd=%0d res=%h",
                                 p, wb_put[p].rd, wb_put[p].res, mon_exp.rd, mon_exp.res);
                    end
                end
                if (p == 1) begin
                    n_cmp++;
                    if (!mon_lane[0]) begin
                        n_bad++;
                        $display("FAIL ll_lowest_port: got port 1 want port 0 (port 0 free)");
                    end
                end
            end else if (wb_put[p] !== '0) begin
                n_bad++;
                $display("FAIL idle_port%0d: got %h want 0", p, wb_put[p]);
            end
        end
        n_cmp++;
        if (mon_n > 1) begin
            n_bad++;
            $display("FAIL one_ll_per_cycle: got %0d writes want <=1", mon_n);
        end
    end

    task automatic test_reset();
        cyc(1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 1'b1, 5'd4, 64'h44);
        n_cmp++;
        if (ll_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b want 1", ll_ready); end
        n_cmp++;
        if (ll_count !== 2'd0) begin n_bad++; $display("FAIL rst_count: got %0d want 0", ll_count); end
        n_cmp++;
        if (wb_put[1].rd_en !== 1'b0) begin n_bad++; $display("FAIL rst_no_ll: got %b want 0", wb_put[1].rd_en); end
        idle();
        n_cmp++;
        if (ll_count !== 2'd0) begin n_bad++; $display("FAIL rst_release_count: got %0d want 0", ll_count); end
    endtask

    task automatic test_bypass();
        sb.push_back(ent(5'd5, 64'h1234));
        cyc(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 64'h1234);
        n_cmp++;
        if (wb_put[0] !== mk(5'd5, 64'h1234)) begin
            n_bad++; $display("FAIL bypass_port0: got %h want %h", wb_put[0], mk(5'd5, 64'h1234));
        end
        idle();
        n_cmp++;
        if (ll_count !== 2'd0) begin n_bad++; $display("FAIL bypass_count: got %0d want 0", ll_count); end
    endtask

    task automatic test_enqueue();
        sb.push_back(ent(5'd7, 64'h77));
        cyc(1'b0, 1'b1, 5'd1, 1'b1, 5'd2, 1'b0, 1'b1, 5'd7, 64'h77);
        idle();
        n_cmp++;
        if (ll_count !== 2'd1) begin n_bad++; $display("FAIL enq_count: got %0d want 1", ll_count); end
        n_cmp++;
        if (wb_put[0] !== mk(5'd7, 64'h77)) begin
            n_bad++; $display("FAIL enq_write: got %h want %h", wb_put[0], mk(5'd7, 64'h77));
        end
        idle();
        n_cmp++;
        if (ll_count !== 2'd0) begin n_bad++; $display("FAIL enq_drain: got %0d want 0", ll_count); end
    endtask

    task automatic test_fill();
        logic [1:0] exp_cnt [3] = '{2'd0, 2'd1, 2'd2};
        logic       exp_rdy [3] = '{1'b1, 1'b1, 1'b0};
        for (int c = 0; c < 3; c++) begin
            if (c < 2) sb.push_back(ent(5'(10 + c), 64'(16 + c)));
            cyc(1'b0, 1'b1, 5'd1, 1'b1, 5'd2, 1'b0, 1'b1, 5'(10 + c), 64'(16 + c));
            n_cmp++;
            if (ll_count !== exp_cnt[c] || ll_ready !== exp_rdy[c]) begin
                n_bad++;
                $display("FAIL fill_c%0d: got count=%0d ready=%b want count=%0d ready=%b",
                         c, ll_count, ll_ready, exp_cnt[c], exp_rdy[c]);
            end
        end
        for (int c = 0; c < 2; c++) begin
            idle();
            n_cmp++;
            if (wb_put[0] !== mk(5'(10 + c), 64'(16 + c)) || ll_count !== 2'(2 - c)) begin
                n_bad++;
                $display("FAIL drain_c%0d: got %h count=%0d want %h count=%0d",
                         c, wb_put[0], ll_count, mk(5'(10 + c), 64'(16 + c)), 2 - c);
            end
        end
        idle();
        n_cmp++;
        if (ll_count !== 2'd0 || ll_ready !== 1'b1) begin
            n_bad++; $display("FAIL drain_end: got count=%0d ready=%b want 0/1", ll_count, ll_ready);
        end
    endtask

    task automatic test_collision();
        sb.push_back(ent(5'd9, 64'h99));
        cyc(1'b0, 1'b1, 5'd1, 1'b1, 5'd2, 1'b0, 1'b1, 5'd9, 64'h99);
        cyc(1'b0, 1'b0, 5'd0, 1'b1, 5'd9, 1'b0, 1'b0, 5'd0, 64'd0);
        n_cmp++;
        if (wb_put[0].rd_en !== 1'b0 || ll_count !== 2'd1) begin
            n_bad++; $display("FAIL collide_defer: got en=%b count=%0d want 0/1", wb_put[0].rd_en, ll_count);
        end
        idle();
        n_cmp++;
        if (wb_put[0] !== mk(5'd9, 64'h99)) begin
            n_bad++; $display("FAIL collide_retry: got %h want %h", wb_put[0], mk(5'd9, 64'h99));
        end
        sb.push_back(ent(5'd20, 64'h20));
        cyc(1'b0, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 1'b1, 5'd20, 64'h20);
        n_cmp++;
        if (wb_put[1] !== mk(5'd20, 64'h20)) begin
            n_bad++; $display("FAIL port1_bypass: got %h want %h", wb_put[1], mk(5'd20, 64'h20));
        end
        idle();
        n_cmp++;
        if (ll_count !== 2'd0) begin n_bad++; $display("FAIL port1_count: got %0d want 0", ll_count); end
    endtask

    task automatic test_stall();
        sb.push_back(ent(5'd14, 64'h14));
        cyc(1'b0, 1'b1, 5'd1, 1'b1, 5'd2, 1'b0, 1'b1, 5'd14, 64'h14);
        cyc(1'b0, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 5'd0, 64'd0);
        n_cmp++;
        if (wb_put[0] !== mk(5'd14, 64'h14) || wb_put[1].rd_en !== 1'b0) begin
            n_bad++; $display("FAIL stall_head: got p0=%h p1_en=%b want %h p1_en=0",
                              wb_put[0], wb_put[1].rd_en, mk(5'd14, 64'h14));
        end
        idle();
        n_cmp++;
        if (ll_count !== 2'd0) begin n_bad++; $display("FAIL stall_count: got %0d want 0", ll_count); end
    endtask

    task automatic test_rd_zero();
        cyc(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 64'hDEAD);
        n_cmp++;
        if (wb_put[0].rd_en !== 1'b0 || wb_put[1].rd_en !== 1'b0) begin
            n_bad++; $display("FAIL rd0_bypass: got en=%b%b want 00", wb_put[1].rd_en, wb_put[0].rd_en);
        end
        sb.push_back(ent(5'd21, 64'h21));
        cyc(1'b0, 1'b1, 5'd1, 1'b1, 5'd2, 1'b0, 1'b1, 5'd21, 64'h21);
        n_cmp++;
        if (ll_count !== 2'd0) begin n_bad++; $display("FAIL rd0_not_queued: got %0d want 0", ll_count); end
        cyc(1'b0, 1'b1, 5'd1, 1'b1, 5'd2, 1'b0, 1'b1, 5'd0, 64'hBEEF);
        idle();
        idle();
        n_cmp++;
        if (ll_count !== 2'd1 || wb_put[0].rd_en !== 1'b0 || wb_put[1].rd_en !== 1'b0) begin
            n_bad++; $display("FAIL rd0_head: got count=%0d en=%b%b want 1/00",
                              ll_count, wb_put[1].rd_en, wb_put[0].rd_en);
        end
        idle();
        n_cmp++;
        if (ll_count !== 2'd0) begin n_bad++; $display("FAIL rd0_retired: got %0d want 0", ll_count); end
    endtask

    task automatic test_back_to_back();
        logic [4:0]  rd;
        logic [63:0] res;
        sb.push_back(ent(5'd22, 64'h22));
        cyc(1'b0, 1'b1, 5'd1, 1'b1, 5'd2, 1'b0, 1'b1, 5'd22, 64'h22);
        sb.push_back(ent(5'd23, 64'h23));
        cyc(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd23, 64'h23);
        n_cmp++;
        if (wb_put[0] !== mk(5'd22, 64'h22) || ll_count !== 2'd1) begin
            n_bad++; $display("FAIL b2b_head: got %h count=%0d want %h count=1",
                              wb_put[0], ll_count, mk(5'd22, 64'h22));
        end
        idle();
        n_cmp++;
        if (wb_put[0] !== mk(5'd23, 64'h23) || ll_count !== 2'd1) begin
            n_bad++; $display("FAIL b2b_swap: got %h count=%0d want %h count=1",
                              wb_put[0], ll_count, mk(5'd23, 64'h23));
        end
        idle();
        for (int k = 0; k < 6; k++) begin
            rd  = 5'($urandom_range(1, 31));
            res = {$urandom, $urandom};
            sb.push_back(ent(rd, res));
            cyc(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, rd, res);
            n_cmp++;
            if (wb_put[0] !== mk(rd, res) || ll_count !== 2'd0) begin
                n_bad++; $display("FAIL b2b_bypass%0d: got %h count=%0d want %h count=0",
                                  k, wb_put[0], ll_count, mk(rd, res));
            end
        end
        idle();
    endtask

    task automatic test_reset_mid();
        sb.push_back(ent(5'd24, 64'h24));
        cyc(1'b0, 1'b1, 5'd1, 1'b1, 5'd2, 1'b0, 1'b1, 5'd24, 64'h24);
        sb.push_back(ent(5'd25, 64'h25));
        cyc(1'b0, 1'b1, 5'd1, 1'b1, 5'd2, 1'b0, 1'b1, 5'd25, 64'h25);
        cyc(1'b0, 1'b1, 5'd1, 1'b1, 5'd2, 1'b0, 1'b0, 5'd0, 64'd0);
        n_cmp++;
        if (ll_count !== 2'd2) begin n_bad++; $display("FAIL mid_full: got %0d want 2", ll_count); end
        sb.delete();
        cyc(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd26, 64'h26);
        n_cmp++;
        if (ll_count !== 2'd0 || ll_ready !== 1'b1) begin
            n_bad++; $display("FAIL mid_rst: got count=%0d ready=%b want 0/1", ll_count, ll_ready);
        end
        for (int k = 0; k < 3; k++) begin
            idle();
            n_cmp++;
            if (ll_count !== 2'd0 || ll_ready !== 1'b1) begin
                n_bad++; $display("FAIL mid_after%0d: got count=%0d ready=%b want 0/1", k, ll_count, ll_ready);
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        stall_wb = 1'b0;
        lane_get = '0;
        ll_valid = 1'b0;
        ll_rd    = 5'd0;
        ll_res   = 64'd0;
        test_reset();
        test_bypass();
        test_enqueue();
        test_fill();
        test_collision();
        test_stall();
        test_rd_zero();
        test_back_to_back();
        test_reset_mid();
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++; $display("FAIL sb_drained: got %0d pending want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_port_sched.md
WB_PORT_SCHED -- requirements
Module: wb_port_sched

Interface
REQ-001 Clock and reset SHALL be one clock, reset asynchronous and active-high.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 stall_wb  input  1  WB stage stall; when high, lane writes are suppressed.
REQ-005 lane_get  input  2 x regpack_t  in-order issue lanes: rd_en, rd[4:0], res[63:0].
REQ-006 ll_valid  input  1  long-latency unit (mul/div) result valid.
REQ-007 ll_ready  output  1  scheduler can accept a long-latency result.
REQ-008 ll_rd  input  5  long-latency destination register.
REQ-009 ll_res  input  64  long-latency result value.
REQ-010 wb_put  output  2 x regpack_t  regfile write ports 0 and 1.
REQ-011 ll_count  output  2  occupied pending-buffer entries, 0..2.

Function
REQ-012 Lane i SHALL drive wb_put[i] with rd_en = lane_get[i].rd_en && !stall_wb && (rd != 0), passing rd and res unchanged.
REQ-013 A port is free in a cycle when its lane write enable from REQ-012 is 0.
REQ-014 Pending buffer: 2-entry FIFO of {rd, res}, with head/tail pointers wrapping modulo 2 and a count register.
REQ-015 ll_ready SHALL equal (count < 2), registered state only, with no dependence on ll_valid.
REQ-016 Accept occurs when ll_valid && ll_ready; the candidate SHALL be the FIFO head if count > 0, else the incoming result (bypass).
REQ-017 At most one long-latency result SHALL be written per cycle, placed on the lowest-numbered free port.
REQ-018 The candidate SHALL be deferred if no port is free or its rd equals the rd of any enabled lane write in the same cycle.
REQ-019 A candidate with rd = 0 SHALL be retired without asserting any write enable.
REQ-020 Bypass latency SHALL be 0 cycles; a buffered result SHALL write no earlier than the cycle after acceptance.
REQ-021 A bypassed result SHALL NOT enter the FIFO; a deferred bypass candidate SHALL be enqueued at the tail.
REQ-022 A simultaneous accept (to FIFO) and head retire SHALL leave count unchanged, with both pointers advancing.
REQ-023 With count = 2 the FIFO SHALL NOT accept; ll_valid is ignored.
REQ-024 FIFO order SHALL be preserved: results retire in acceptance order.
REQ-025 A disabled port SHALL drive rd = 0 and res = 0 unless carrying a lane or long-latency write.

Reset
REQ-026 On rst, count SHALL be 0, head and tail pointers 0, and FIFO contents discarded.
REQ-027 During reset, ll_ready SHALL be 1 and ll_count 0; wb_put enables follow REQ-012 only.
REQ-028 Reset mid-operation SHALL drop pending results with no write issued for them.

Structure
REQ-029 regpack_t, the ISSUE_NUM constant (2), and the pending-entry struct {rd, res} SHALL reside in the shared CPU definitions package.
REQ-030 The 2-entry FIFO SHALL be one sub-module, wb_ll_fifo, with push/pop/count ports.
REQ-031 Port selection and collision checks SHALL be combinational in wb_port_sched.

Verification
REQ-032 Both lanes idle, ll_valid with rd=5 and res=0x1234, count 0 -> same cycle wb_put[0]={1,5,0x1234}; count stays 0.
REQ-033 Both lanes writing rd=1 and rd=2, ll_valid with rd=7 -> ll result enqueued (count 1); next cycle with lanes idle -> wb_put[0]={1,7,...}, count 0.
REQ-034 Lanes busy for 3 cycles, ll_valid held high -> count 1 then 2, ll_ready=0 in the third cycle; lanes idle -> FIFO drains one per cycle in order.
REQ-035 Lane0 idle, lane1 writing rd=9, head rd=9 -> deferred; the next cycle with no collision -> written on port 0.
REQ-036 stall_wb=1 with both lanes valid and a pending head -> lanes suppressed; head written on port 0.
REQ-037 count=2, assert rst for one cycle -> count 0, ll_ready 1, and no write for the dropped entries.
